// File: rtl/dve_err_pkg.sv
// Shared widths and interrupt state encoding for the DVE error reporter.
package dve_err_pkg;

    localparam int CNT_W_DEF   = 32;
    localparam int CERR_W_DEF  = 16;
    localparam int THRES_W_DEF = 10;

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } irq_state_t;

    // A same-cycle event outranks the clear, so no interrupt is ever lost.
    function automatic irq_state_t irq_next(
        input irq_state_t st,
        input logic       ev,
        input logic       clr
    );
        irq_state_t nxt;
        nxt = st;
        if (ev) begin
            nxt = PEND;
        end else if (clr) begin
            nxt = IDLE;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/dve_err_sat_cnt.sv
// Saturating up-counter with clear-then-add semantics.
module dve_err_sat_cnt #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr_i,
    input  logic [1:0]   inc_i,
    output logic [W-1:0] cnt_o,
    output logic [W-1:0] nxt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;
    logic [W-1:0] base;
    logic [W:0]   sum;

    always_comb begin
        base  = clr_i ? '0 : cnt_q;
        sum   = {1'b0, base} + {{(W - 1){1'b0}}, inc_i};
        cnt_d = sum[W] ? '1 : sum[W-1:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
    assign nxt_o = cnt_d;

endmodule

// File: rtl/dve_err_reporter.sv
// Memory ECC error reporter: per-memory counters, sticky faults and IRQs.
module dve_err_reporter
    import dve_err_pkg::*;
#(
    parameter int CNT_W   = CNT_W_DEF,
    parameter int CERR_W  = CERR_W_DEF,
    parameter int THRES_W = THRES_W_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               mem0_sbe_vld,
    input  logic               mem0_dbe_vld,
    input  logic               mem1_sbe_vld,
    input  logic               mem1_dbe_vld,
    input  logic               csr_cerr_irq_en,
    input  logic               csr_uerr_irq_en,
    input  logic [THRES_W-1:0] csr_cerr_threshold,
    input  logic               csr_cnt_clr,
    input  logic               csr_irq_c_clr,
    input  logic               csr_irq_uc_clr,
    input  logic               csr_fault_clr,
    output logic               IRQ_C,
    output logic               IRQ_UC,
    output logic [CNT_W-1:0]   single_bit_count0,
    output logic [CNT_W-1:0]   single_bit_count1,
    output logic [CNT_W-1:0]   double_bit_count0,
    output logic [CNT_W-1:0]   double_bit_count1,
    output logic [CERR_W-1:0]  cerr_counter,
    output logic [THRES_W-1:0] cerr_threshold,
    output logic               cerr_over_thres_fault,
    output logic               fault_mission_fault,
    output logic               fault_latent_fault
);

    localparam int CMP_W = (CERR_W > THRES_W) ? CERR_W : THRES_W;

    logic [CNT_W-1:0]   s0_nxt, s1_nxt, d0_nxt, d1_nxt;
    logic [CERR_W-1:0]  cerr_nxt;
    logic [1:0]         cerr_inc;
    logic [CMP_W-1:0]   cerr_ext, thr_ext;
    logic [THRES_W-1:0] thr_q;
    logic               over_set, any_sbe, any_dbe;
    logic               over_q, mission_q, latent_q;
    logic               irq_c_q, irq_uc_q;
    irq_state_t         c_st_q, c_st_d, uc_st_q, uc_st_d;

    assign any_sbe  = mem0_sbe_vld | mem1_sbe_vld;
    assign any_dbe  = mem0_dbe_vld | mem1_dbe_vld;
    assign cerr_inc = {1'b0, mem0_sbe_vld} + {1'b0, mem1_sbe_vld};

    dve_err_sat_cnt #(.W(CNT_W)) u_sbe0 (
        .clk(clk), .reset(reset), .clr_i(csr_cnt_clr),
        .inc_i({1'b0, mem0_sbe_vld}),
        .cnt_o(single_bit_count0), .nxt_o(s0_nxt)
    );

    dve_err_sat_cnt #(.W(CNT_W)) u_sbe1 (
        .clk(clk), .reset(reset), .clr_i(csr_cnt_clr),
        .inc_i({1'b0, mem1_sbe_vld}),
        .cnt_o(single_bit_count1), .nxt_o(s1_nxt)
    );

    dve_err_sat_cnt #(.W(CNT_W)) u_dbe0 (
        .clk(clk), .reset(reset), .clr_i(csr_cnt_clr),
        .inc_i({1'b0, mem0_dbe_vld}),
        .cnt_o(double_bit_count0), .nxt_o(d0_nxt)
    );

    dve_err_sat_cnt #(.W(CNT_W)) u_dbe1 (
        .clk(clk), .reset(reset), .clr_i(csr_cnt_clr),
        .inc_i({1'b0, mem1_dbe_vld}),
        .cnt_o(double_bit_count1), .nxt_o(d1_nxt)
    );

    dve_err_sat_cnt #(.W(CERR_W)) u_cerr (
        .clk(clk), .reset(reset), .clr_i(csr_cnt_clr),
        .inc_i(cerr_inc),
        .cnt_o(cerr_counter), .nxt_o(cerr_nxt)
    );

    // Compare the upcoming count against the threshold already registered.
    assign cerr_ext = CMP_W'(cerr_nxt);
    assign thr_ext  = CMP_W'(thr_q);
    assign over_set = (thr_q != '0) && (cerr_ext > thr_ext);

    always_ff @(posedge clk) begin
        if (reset) begin
            thr_q     <= '0;
            over_q    <= 1'b0;
            latent_q  <= 1'b0;
            mission_q <= 1'b0;
        end else begin
            thr_q     <= csr_cerr_threshold;
            over_q    <= over_set | (over_q & ~csr_fault_clr);
            latent_q  <= over_set | (latent_q & ~csr_fault_clr);
            mission_q <= any_dbe | (mission_q & ~csr_fault_clr);
        end
    end

    assign c_st_d  = irq_next(c_st_q, any_sbe, csr_irq_c_clr);
    assign uc_st_d = irq_next(uc_st_q, any_dbe, csr_irq_uc_clr);

    always_ff @(posedge clk) begin
        if (reset) begin
            c_st_q   <= IDLE;
            uc_st_q  <= IDLE;
            irq_c_q  <= 1'b0;
            irq_uc_q <= 1'b0;
        end else begin
            c_st_q   <= c_st_d;
            uc_st_q  <= uc_st_d;
            irq_c_q  <= (c_st_d == PEND) & csr_cerr_irq_en;
            irq_uc_q <= (uc_st_d == PEND) & csr_uerr_irq_en;
        end
    end

    assign IRQ_C                 = irq_c_q;
    assign IRQ_UC                = irq_uc_q;
    assign cerr_threshold        = thr_q;
    assign cerr_over_thres_fault = over_q;
    assign fault_mission_fault   = mission_q;
    assign fault_latent_fault    = latent_q;

endmodule

// File: doc/dve_err_reporter.md
DVE_ERR_REPORTER -- requirements
Module: dve_err_reporter

Interface
REQ-001 Parameter CNT_W, default 32, width of the single/double-bit error counters.
REQ-002 Parameter CERR_W, default 16, width of the correctable-error accumulator.
REQ-003 Parameter THRES_W, default 10, width of the correctable-error threshold.
REQ-004 One clock; reset is synchronous and active-high.
REQ-005 clk  in  1  block clock; all state updates on rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 mem0_sbe_vld  in  1  memory 0 single-bit (corrected) error pulse, one event per cycle high.
REQ-008 mem0_dbe_vld  in  1  memory 0 double-bit (uncorrectable) error pulse.
REQ-009 mem1_sbe_vld  in  1  memory 1 single-bit error pulse.
REQ-010 mem1_dbe_vld  in  1  memory 1 double-bit error pulse.
REQ-011 csr_cerr_irq_en  in  1  correctable interrupt enable.
REQ-012 csr_uerr_irq_en  in  1  uncorrectable interrupt enable.
REQ-013 csr_cerr_threshold  in  THRES_W  correctable-error fault threshold; 0 disables the threshold fault.
REQ-014 csr_cnt_clr  in  1  pulse; clears all error counters.
REQ-015 csr_irq_c_clr  in  1  W1C pulse for IRQ_C.
REQ-016 csr_irq_uc_clr  in  1  W1C pulse for IRQ_UC.
REQ-017 csr_fault_clr  in  1  pulse; clears all sticky fault outputs.
REQ-018 IRQ_C / IRQ_UC  out  1 each  correctable / uncorrectable interrupts.
REQ-019 single_bit_count0/1, double_bit_count0/1  out  CNT_W each  per-memory error counts.
REQ-020 cerr_counter  out  CERR_W  combined correctable-error count; cerr_threshold  out  THRES_W  registered copy of csr_cerr_threshold.
REQ-021 cerr_over_thres_fault, fault_mission_fault, fault_latent_fault  out  1 each  sticky fault flags.

Function
REQ-022 Each *_vld input high increments its counter by 1 on the next edge; result visible at N+1.
REQ-023 All counters saturate at all-ones; no wrap.
REQ-024 cerr_counter adds the number of sbe pulses in the cycle (0, 1 or 2), saturating at 0xFFFF.
REQ-025 sbe and dbe on the same memory in the same cycle are both counted.
REQ-026 csr_cnt_clr with a simultaneous event: the counter takes the event contribution alone (clear, then add).
REQ-027 cerr_threshold updates from csr_cerr_threshold every cycle (1-cycle latency).
REQ-028 cerr_over_thres_fault sets when threshold != 0 and next cerr_counter > cerr_threshold; sticky until csr_fault_clr.
REQ-029 fault_mission_fault sets on any dbe pulse; fault_latent_fault sets with cerr_over_thres_fault; both sticky.
REQ-030 csr_fault_clr with a simultaneous setting condition: the set wins.
REQ-031 Per-class interrupt FSM, states IDLE/PEND.
REQ-032 IDLE->PEND on any event of the class (sbe for C, dbe for UC), regardless of enable.
REQ-033 PEND->IDLE on the class clr pulse; a same-cycle event keeps the FSM in PEND.
REQ-034 IRQ_C = (C state == PEND) & csr_cerr_irq_en, registered; IRQ_UC likewise with csr_uerr_irq_en.
REQ-035 Event-to-IRQ latency is 1 cycle. Toggling an enable while PEND masks or unmasks the IRQ without losing the pending state.

Reset
REQ-036 On reset all counters, cerr_threshold, fault flags and IRQs are 0, and both FSMs are IDLE at the next edge.
REQ-037 Inputs are ignored while reset is high. Reset mid-operation discards all pending state.

Structure
REQ-038 Package dve_err_pkg holds CNT_W/CERR_W/THRES_W defaults and the irq_state_t enum {IDLE, PEND}.
REQ-039 Sub-module dve_err_sat_cnt (saturating counter: clr, inc amount, width parameter) is instantiated for all five counters.

Verification
REQ-040 mem0_sbe_vld for 3 cycles, en=1 -> single_bit_count0=3, cerr_counter=3, IRQ_C=1 one cycle after the first pulse.
REQ-041 mem0_sbe_vld and mem1_sbe_vld in the same cycle, threshold=1 -> cerr_counter=2, cerr_over_thres_fault=1, fault_latent_fault=1 at N+1.
REQ-042 Preload single_bit_count1=0xFFFFFFFF via a forced pulse train, then one more pulse -> stays 0xFFFFFFFF.
REQ-043 mem1_dbe_vld with csr_irq_uc_clr in the same cycle -> IRQ_UC stays 1, double_bit_count1=1, fault_mission_fault=1.
REQ-044 csr_cnt_clr plus mem0_dbe_vld in the same cycle with double_bit_count0=5 -> double_bit_count0=1.
REQ-045 Reset asserted mid-burst with IRQ_C=1 and counts nonzero -> all outputs 0 at the next edge; pulses during reset are not counted.
